conv_result_writer: RTL and testbench

- Terminal stage of the binary convolution pipeline; the consumer of the conv-stage chain.
- Each valid beat carries one negative_flag per tap of a convolution window, plus the write address and bit index that travelled down the chain with it.
- Counts negative products and takes the majority sign as the output bit.
- Packs output bits into 16-bit words and issues one-cycle SRAM writes. Signals done after the final word of a layer has been written.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/popcount_sign.sv | 27 ++
 rtl/conv_result_writer.sv | 143 ++++++++++++++
 tb/tb_conv_result_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, polarity definitions and FSM state type for the binary
// convolution pipeline.
package conv_pkg;

   localparam int NUM_TAPS = 9;    // taps per 3x3 window
   localparam int CNT_W    = 4;    // popcount width, 2^CNT_W > NUM_TAPS
   localparam int ADDR_W   = 12;   // SRAM word address width
   localparam int IDX_W    = 4;    // bit index within an output word
   localparam int WORD_W   = 16;   // SRAM word width, 2^IDX_W

   // A set negative_flag marks a negative product; a set result bit marks
   // a positive-majority window.
   localparam logic NEG     = 1'b1;
   localparam logic POS_BIT = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/popcount_sign.sv
// Combinational popcount of negative flags followed by a majority compare.
// A window is positive only when strictly fewer than half of its taps are
// negative, so a tie (even tap counts) resolves to the negative bit.
module popcount_sign
   import conv_pkg::*;
#(
   parameter int P_TAPS  = 9,
   parameter int P_CNT_W = 4
) (
   input  logic [P_TAPS-1:0] i_flags,
   output logic              o_result
);

   logic [P_CNT_W-1:0] w_neg_cnt;
   logic [P_CNT_W:0]   w_twice;

   // Count negative taps, then compare twice the count against the tap total.
   always_comb begin
      w_neg_cnt = '0;
      for (int i = 0; i < P_TAPS; i++) begin
         w_neg_cnt = w_neg_cnt + P_CNT_W'(i_flags[i] == NEG);
      end
      w_twice  = {w_neg_cnt, 1'b0};
      o_result = (w_twice < (P_CNT_W + 1)'(P_TAPS)) ? POS_BIT : ~POS_BIT;
   end

endmodule

// File: rtl/conv_result_writer.sv
// Terminal stage of the binary convolution chain: turns each window's
// negative flags into a majority sign bit, packs bits into SRAM words and
// issues one-cycle write strobes. done marks the end of a layer.
module conv_result_writer
   import conv_pkg::*;
#(
   parameter int P_TAPS   = conv_pkg::NUM_TAPS,
   parameter int P_CNT_W  = conv_pkg::CNT_W,
   parameter int P_ADDR_W = conv_pkg::ADDR_W,
   parameter int P_IDX_W  = conv_pkg::IDX_W,
   parameter int P_WORD_W = conv_pkg::WORD_W
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_go,
   input  logic                i_valid_in,
   input  logic [P_TAPS-1:0]   i_negative_flags,
   input  logic [P_ADDR_W-1:0] i_write_addr_in,
   input  logic [P_IDX_W-1:0]  i_idx_in,
   input  logic                i_last_in,
   output logic                o_sram_write_enable,
   output logic [P_ADDR_W-1:0] o_sram_write_address,
   output logic [P_WORD_W-1:0] o_sram_write_data,
   output logic                o_done
);

   state_t                r_state;
   state_t                w_state_next;

   logic                  w_result;
   logic                  w_accept;

   logic                  r_s1_valid;
   logic                  r_s1_result;
   logic                  r_s1_last;
   logic [P_ADDR_W-1:0]   r_s1_addr;
   logic [P_IDX_W-1:0]    r_s1_idx;

   logic [P_WORD_W-1:0]   r_pack;
   logic [P_WORD_W-1:0]   w_merged;
   logic                  w_flush;

   logic                  r_we;
   logic [P_ADDR_W-1:0]   r_waddr;
   logic [P_WORD_W-1:0]   r_wdata;

   popcount_sign #(
      .P_TAPS  (P_TAPS),
      .P_CNT_W (P_CNT_W)
   ) u_popcount_sign (
      .i_flags  (i_negative_flags),
      .o_result (w_result)
   );

   // Beats count only while running; once the last beat is in stage 1 the
   // layer is closed and later beats are dropped.
   assign w_accept = i_go && (r_state == RUN) && i_valid_in
                     && !(r_s1_valid && r_s1_last);

   // Stage 1: register the sign bit with its address, index and last tag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_result <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_addr   <= '0;
         r_s1_idx    <= '0;
      end else begin
         r_s1_valid  <= w_accept;
         r_s1_result <= w_result;
         r_s1_last   <= i_last_in;
         r_s1_addr   <= i_write_addr_in;
         r_s1_idx    <= i_idx_in;
      end
   end

   // Merge the stage-1 bit into the pack buffer and decide whether this
   // beat closes the word.
   always_comb begin
      w_merged           = r_pack;
      w_merged[r_s1_idx] = r_s1_result;
      w_flush            = r_s1_valid
                           && ((r_s1_idx == P_IDX_W'(P_WORD_W - 1)) || r_s1_last);
   end

   // Stage 2: pack bits, emit a one-cycle write on flush, clear on go low.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pack  <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (!i_go) begin
         r_pack  <= '0;
         r_we    <= 1'b0;
      end else if (w_flush) begin
         r_pack  <= '0;
         r_we    <= 1'b1;
         r_waddr <= r_s1_addr;
         r_wdata <= w_merged;
      end else begin
         r_we    <= 1'b0;
         if (r_s1_valid) begin
            r_pack <= w_merged;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next state and done output. FLUSH lasts exactly the strobe cycle,
   // since the strobe is registered on the same edge that enters FLUSH.
   always_comb begin
      w_state_next = r_state;
      o_done       = 1'b0;
      if (!i_go) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_next = RUN;
            RUN:     if (r_s1_valid && r_s1_last) w_state_next = FLUSH;
            FLUSH:   w_state_next = DONE;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
         endcase
      end
      if (r_state == DONE) begin
         o_done = 1'b1;
      end
   end

   assign o_sram_write_enable  = r_we;
   assign o_sram_write_address = r_waddr;
   assign o_sram_write_data    = r_wdata;

endmodule

// File: tb/tb_conv_result_writer.sv
// Scoreboard bench for conv_result_writer: stimulus feeds a word-level
// reference model that queues expected writes; a monitor pops on every strobe.
module tb_conv_result_writer;

   logic        clk;
   logic        rst_n;
   logic        go;
   logic        valid_in;
   logic [8:0]  flags;
   logic [11:0] addr_in;
   logic [3:0]  idx_in;
   logic        last_in;
   logic        we;
   logic [11:0] waddr;
   logic [15:0] wdata;
   logic        done;

   typedef struct {
      logic [11:0] addr;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] m_word;
   int          cyc;
   int          checks;
   int          failures;

   conv_result_writer dut (
      .i_clk                (clk),
      .i_rst_n              (rst_n),
      .i_go                 (go),
      .i_valid_in           (valid_in),
      .i_negative_flags     (flags),
      .i_write_addr_in      (addr_in),
      .i_idx_in             (idx_in),
      .i_last_in            (last_in),
      .o_sram_write_enable  (we),
      .o_sram_write_address (waddr),
      .o_sram_write_data    (wdata),
      .o_done               (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=addr 0x%0h data 0x%0h required=no write (cycle %0d)",
                     waddr, wdata, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("write_addr", 32'(waddr), 32'(e.addr));
            chk("write_data", 32'(wdata), 32'(e.data));
            chk("write_cycle", 32'(cyc), 32'(e.cyc));
            $display("write addr=0x%03h data=0x%04h cycle=%0d", waddr, wdata, cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a window is positive iff fewer than half its 9 taps
   // are negative; a word is written when bit 15 or a last beat arrives.
   task automatic model_beat(input logic [8:0] f, input logic [11:0] a,
                             input logic [3:0] idx, input logic last);
      exp_t e;
      m_word[idx] = (2 * $countones(f) < 9);
      if (idx == 4'd15 || last) begin
         e.addr = a;
         e.data = m_word;
         e.cyc  = cyc + 2;
         exp_q.push_back(e);
         m_word = 16'h0000;
      end
   endtask

   task automatic send(input logic [8:0] f, input logic [11:0] a,
                       input logic [3:0] idx, input logic last, input bit accepted);
      valid_in = 1'b1;
      flags    = f;
      addr_in  = a;
      idx_in   = idx;
      last_in  = last;
      if (accepted) model_beat(f, a, idx, last);
      step();
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic start();
      go = 1'b1;
      step();
   endtask

   task automatic stop();
      go = 1'b0;
      step();
      m_word = 16'h0000;
   endtask

   // After send() of a last beat: strobe next cycle, done the cycle after.
   task automatic check_done_seq(input string name);
      step();
      chk({name, "_done_low_at_strobe"}, 32'(done), 32'd0);
      step();
      chk({name, "_done_high"}, 32'(done), 32'd1);
      repeat (3) step();
      chk({name, "_done_held"}, 32'(done), 32'd1);
      go = 1'b0;
      step();
      chk({name, "_done_cleared"}, 32'(done), 32'd0);
      m_word = 16'h0000;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      m_word   = 16'h0000;
      rst_n    = 1'b0;
      go       = 1'b0;
      valid_in = 1'b0;
      flags    = '0;
      addr_in  = '0;
      idx_in   = '0;
      last_in  = 1'b0;

      // Reset state.
      repeat (2) step();
      chk("reset_we", 32'(we), 32'd0);
      chk("reset_addr", 32'(waddr), 32'd0);
      chk("reset_data", 32'(wdata), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      step();

      // Reset mid-word: the partial word is discarded.
      start();
      for (int i = 0; i < 5; i++) send(9'($urandom), 12'h010, 4'(i), 1'b0, 1'b1);
      rst_n = 1'b0;
      go    = 1'b0;
      m_word = 16'h0000;
      #1;
      chk("midreset_we", 32'(we), 32'd0);
      step();
      rst_n = 1'b1;
      start();
      for (int i = 0; i < 16; i++) send(9'h000, 12'h010, 4'(i), 1'b0, 1'b1);
      step();
      stop();

      // Majority threshold: 4 negatives positive, 5 negatives negative.
      start();
      for (int i = 0; i < 16; i++)
         send((i % 2 == 0) ? 9'h00F : 9'h01F, 12'h001, 4'(i), 1'b0, 1'b1);
      step();
      stop();

      // Early flush on last, with done handshake.
      start();
      for (int i = 0; i < 3; i++) send(9'h000, 12'h0AB, 4'(i), (i == 2), 1'b1);
      check_done_seq("early_last");

      // Back-to-back words.
      start();
      for (int i = 0; i < 32; i++)
         send((i < 16) ? 9'h1FF : 9'h000, (i < 16) ? 12'h002 : 12'h003, 4'(i % 16), 1'b0, 1'b1);
      step();
      stop();

      // Gating by go: beats with go low are ignored, dropping go clears.
      for (int i = 0; i < 4; i++) send(9'($urandom), 12'h0FF, 4'(12 + i), (i == 3), 1'b0);
      start();
      for (int i = 0; i < 8; i++) send(9'($urandom), 12'h020, 4'(i), 1'b0, 1'b1);
      stop();
      chk("gating_done", 32'(done), 32'd0);
      start();
      for (int i = 8; i < 16; i++) send(9'h000, 12'h021, 4'(i), 1'b0, 1'b1);
      step();
      stop();

      // Duplicate index: second idx-3 beat overwrites with a negative bit.
      start();
      send(9'h000, 12'h030, 4'd3, 1'b0, 1'b1);
      send(9'h1FF, 12'h030, 4'd3, 1'b0, 1'b1);
      send(9'h000, 12'h030, 4'd15, 1'b1, 1'b1);
      check_done_seq("dup_idx");

      // Randomized words with idle gaps, ending in a partial word with last.
      start();
      for (int w = 0; w < 4; w++) begin
         logic [11:0] a;
         a = 12'($urandom);
         for (int i = 0; i < 16; i++) begin
            send(9'($urandom), a, 4'(i), 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) step();
         end
      end
      begin
         int n;
         logic [11:0] a;
         n = $urandom_range(1, 14);
         a = 12'($urandom);
         for (int i = 0; i < n; i++) send(9'($urandom), a, 4'(i), (i == n - 1), 1'b1);
      end
      check_done_seq("random_last");

      repeat (4) step();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
